matrix_scan_scheduler: RTL and testbench

MATRIX_SCAN_SCHEDULER -- requirements
Module: matrix_scan_scheduler

---
 rtl/matrix_pkg.sv | 19 +
 rtl/matrix_scan_scheduler_pixel_ram.sv | 30 +++
 rtl/matrix_scan_scheduler.sv | 168 ++++++++++++++++
 tb/tb_matrix_scan_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared defaults, scan FSM state encoding and pixel type for the LED matrix scan scheduler.
package matrix_pkg;

    localparam int DEF_COLS        = 32;
    localparam int DEF_ROWS        = 16;
    localparam int DEF_HOLD_CYCLES = 256;

    typedef enum logic [2:0] {
        ST_PREFETCH,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_HOLD
    } state_t;

    // {top r,g,b, bottom r,g,b}
    typedef logic [5:0] pixel_t;

endpackage

// File: rtl/matrix_scan_scheduler_pixel_ram.sv
// Single-port pixel store: one access per cycle, write or registered read.
module pixel_ram
    import matrix_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    localparam int DEPTH = 1 << AW;

    pixel_t mem [DEPTH];

    // Read data only moves on a read, so it stays valid across both shift phases.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Panel scan scheduler: shifts row r+1 into the panel while row r is displayed,
// and slots pixel writes into the memory cycles the scan does not need.
module matrix_scan_scheduler
    import matrix_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       r2,
    output logic       g2,
    output logic       b2,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       led_clk,
    output logic       lat,
    output logic       oe,
    output logic       frame_done
);

    localparam int CW      = $clog2(COLS);
    localparam int RW      = $clog2(ROWS);
    localparam int AW      = RW + CW;
    localparam int CNT_TOP = (2 * COLS > HOLD_CYCLES) ? 2 * COLS : HOLD_CYCLES;
    localparam int NW      = $clog2(CNT_TOP);

    state_t          state_reg, state_next;
    logic [NW-1:0]   cnt_reg, cnt_next;
    logic [RW-1:0]   shift_row_reg;
    logic [RW-1:0]   disp_row_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic            latched_reg;

    logic [CW-1:0]   shift_col;
    logic            shift_phase;
    logic            in_shift;
    logic            last_col;
    logic            rd_en;
    logic [CW-1:0]   rd_col;
    logic            wr_fire;
    logic [AW-1:0]   wr_target;
    logic [AW-1:0]   wr_addr_next;
    logic [AW-1:0]   ram_addr;
    pixel_t          ram_rdata;
    pixel_t          pix_out;
    logic [RW-1:0]   row_sel;
    logic [3:0]      row_pins;
    logic            unused_bit;

    assign unused_bit = wr_data[6];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_PREFETCH: begin
                state_next = ST_SHIFT;
                cnt_next   = '0;
            end
            ST_SHIFT: begin
                if (cnt_reg == NW'(2 * COLS - 1)) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + NW'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_reg == NW'(1)) begin
                    state_next = ST_LATCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + NW'(1);
                end
            end
            ST_LATCH: begin
                state_next = ST_HOLD;
                cnt_next   = '0;
            end
            ST_HOLD: begin
                if (cnt_reg == NW'(HOLD_CYCLES - 1)) begin
                    state_next = ST_PREFETCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + NW'(1);
                end
            end
            default: begin
                state_next = ST_PREFETCH;
                cnt_next   = '0;
            end
        endcase
    end

    assign in_shift    = (state_reg == ST_SHIFT);
    assign shift_col   = cnt_reg[CW:1];
    assign shift_phase = cnt_reg[0];
    assign last_col    = (shift_col == CW'(COLS - 1));

    // Scan reads own the memory port; the write path only gets the leftover cycles.
    assign rd_en    = (state_reg == ST_PREFETCH) || (in_shift && shift_phase && !last_col);
    assign rd_col   = (state_reg == ST_PREFETCH) ? '0 : shift_col + CW'(1);
    assign wr_ready = !rd_en;
    assign wr_fire  = wr_valid && wr_ready;

    // Start-of-frame byte re-synchronises the write pointer to pixel 0.
    assign wr_target    = wr_data[7] ? '0 : wr_addr_reg;
    assign wr_addr_next = wr_target + AW'(1);
    assign ram_addr     = rd_en ? {shift_row_reg, rd_col} : wr_target;

    pixel_ram #(
        .AW (AW)
    ) u_pixel_ram (
        .clk   (clk),
        .en    (rd_en || wr_fire),
        .we    (wr_fire),
        .addr  (ram_addr),
        .wdata (wr_data[5:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_PREFETCH;
            cnt_reg       <= '0;
            shift_row_reg <= '0;
            disp_row_reg  <= '0;
            wr_addr_reg   <= '0;
            latched_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (wr_fire) begin
                wr_addr_reg <= wr_addr_next;
            end
            if (state_reg == ST_LATCH) begin
                disp_row_reg  <= shift_row_reg;
                shift_row_reg <= (shift_row_reg == RW'(ROWS - 1)) ? '0 : shift_row_reg + RW'(1);
                latched_reg   <= 1'b1;
            end
        end
    end

    assign pix_out = in_shift ? ram_rdata : '0;
    assign {r1, g1, b1, r2, g2, b2} = pix_out;

    assign led_clk    = in_shift && shift_phase;
    assign lat        = (state_reg == ST_LATCH);
    assign frame_done = (state_reg == ST_LATCH) && (shift_row_reg == RW'(ROWS - 1));
    assign oe         = !(latched_reg && ((state_reg == ST_PREFETCH) || in_shift ||
                                          (state_reg == ST_HOLD)));

    // Row address moves to the new row during LATCH so it never changes while lit.
    assign row_sel  = (state_reg == ST_LATCH) ? shift_row_reg : disp_row_reg;
    assign row_pins = 4'(row_sel);
    assign {d, c, b, a} = row_pins;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Directed bench for matrix_scan_scheduler: scan timing, write arbitration, pixel path, resets.
module tb_matrix_scan_scheduler;

    localparam int COLS  = 32;
    localparam int ROWS  = 16;
    localparam int HOLD  = 256;
    localparam int RP    = 2 * COLS + 4 + HOLD;  // 324-cycle row period
    localparam int LP    = 2 * COLS + 3;         // LATCH offset in the period (67)
    localparam int FRAME = RP * ROWS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       r1, g1, b1, r2, g2, b2;
    logic       a, b, c, d;
    logic       led_clk, lat, oe, frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int kc = 0;

    matrix_scan_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .r1         (r1),
        .g1         (g1),
        .b1         (b1),
        .r2         (r2),
        .g2         (g2),
        .b2         (b2),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .led_clk    (led_clk),
        .lat        (lat),
        .oe         (oe),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; cycle 0 is the first PREFETCH.
    always @(posedge clk or negedge reset) begin
        if (!reset) kc <= 0;
        else        kc <= kc + 1;
    end

    function automatic logic [5:0] rgb();
        return {r1, g1, b1, r2, g2, b2};
    endfunction

    function automatic logic [8:0] ctrl();
        return {oe, lat, led_clk, wr_ready, frame_done, d, c, b, a};
    endfunction

    // Expected {oe, lat, led_clk, wr_ready, frame_done, d,c,b,a} at cycle k after reset.
    function automatic logic [8:0] exp_ctrl(input int k);
        int n, p, col;
        logic sh, ph, bl, ltc, e_oe, rdy, fd;
        logic [3:0] row;
        n   = k / RP;
        p   = k % RP;
        sh  = (p >= 1) && (p <= 2 * COLS);
        ph  = sh && (((p - 1) % 2) == 1);
        col = (p - 1) / 2;
        bl  = (p == LP - 2) || (p == LP - 1);
        ltc = (p == LP);
        e_oe = (bl || ltc || k <= LP);
        if (ltc)          row = 4'(n % ROWS);
        else if (k < LP)  row = 4'd0;
        else if (p > LP)  row = 4'(n % ROWS);
        else              row = 4'((n - 1) % ROWS);
        rdy = !((p == 0) || (ph && col < COLS - 1));
        fd  = ltc && ((n % ROWS) == ROWS - 1);
        return {e_oe, ltc, ph, rdy, fd, row};
    endfunction

    task automatic goto(input int k);
        int guard = 0;
        while (kc < k && guard < 100000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic push(input logic [7:0] data);
        int guard = 0;
        wr_valid = 1'b1;
        wr_data  = data;
        while (wr_ready !== 1'b1 && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL push_timeout data=%h got wr_ready=%b want 1", data, wr_ready);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        wr_valid = 1'b1;
        wr_data  = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (oe !== 1'b1) begin n_bad++; $display("FAIL reset_oe got %b want 1", oe); end
        n_cmp++;
        if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        n_cmp++;
        if ({lat, led_clk, frame_done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_strobes got %b want 000", {lat, led_clk, frame_done});
        end
        n_cmp++;
        if (rgb() !== 6'h00) begin n_bad++; $display("FAIL reset_rgb got %h want 00", rgb()); end
        n_cmp++;
        if ({d, c, b, a} !== 4'h0) begin n_bad++; $display("FAIL reset_row got %h want 0", {d, c, b, a}); end
        wr_valid = 1'b0;
    endtask

    task automatic test_startup();
        logic [8:0] e;
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int k = 0; k < LP + (ROWS - 1) * RP; k++) begin
            goto(k);
            e = exp_ctrl(k);
            n_cmp++;
            if (ctrl() !== e) begin
                n_bad++;
                $display("FAIL startup_ctrl k=%0d got %b want %b", k, ctrl(), e);
            end
        end
    endtask

    task automatic test_frame_wrap();
        goto(LP + 15 * RP);
        n_cmp++;
        if ({lat, oe, frame_done, d, c, b, a} !== 7'b111_1111) begin
            n_bad++;
            $display("FAIL wrap_row15_latch got %b want 1111111", {lat, oe, frame_done, d, c, b, a});
        end
        goto(LP + 15 * RP + 1);
        n_cmp++;
        if ({oe, frame_done, d, c, b, a} !== 6'b00_1111) begin
            n_bad++;
            $display("FAIL wrap_row15_hold got %b want 001111", {oe, frame_done, d, c, b, a});
        end
        goto(LP + 16 * RP);
        n_cmp++;
        if ({lat, oe, frame_done, d, c, b, a} !== 7'b110_0000) begin
            n_bad++;
            $display("FAIL wrap_row0_latch got %b want 1100000", {lat, oe, frame_done, d, c, b, a});
        end
        goto(LP + 17 * RP);
        n_cmp++;
        if ({lat, oe, frame_done, d, c, b, a} !== 7'b110_0001) begin
            n_bad++;
            $display("FAIL wrap_row1_latch got %b want 1100001", {lat, oe, frame_done, d, c, b, a});
        end
    endtask

    // 0x80 then 0x3F x511 with wr_valid held; also counts grants in a PREFETCH+SHIFT window.
    task automatic test_fill();
        int accepted = 0;
        int win_cnt = 0;
        int guard = 0;
        int k, p;
        logic win_open = 1'b0;
        logic [8:0] e;
        while (accepted < 512 && guard < 2000) begin
            k = kc;
            p = k % RP;
            wr_valid = 1'b1;
            wr_data  = (accepted == 0) ? 8'h80 : 8'h3F;
            e = exp_ctrl(k);
            n_cmp++;
            if (ctrl() !== e) begin
                n_bad++;
                $display("FAIL fill_ctrl k=%0d got %b want %b", k, ctrl(), e);
            end
            if (p == 0) begin
                win_open = 1'b1;
                win_cnt  = 0;
            end
            if (wr_ready === 1'b1) begin
                accepted++;
                if (win_open) win_cnt++;
            end
            if (p == 2 * COLS && win_open) begin
                win_open = 1'b0;
                n_cmp++;
                if (win_cnt != 33) begin
                    n_bad++;
                    $display("FAIL fill_window_grants got %0d want 33", win_cnt);
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        wr_valid = 1'b0;
        n_cmp++;
        if (accepted != 512) begin
            n_bad++;
            $display("FAIL fill_accepted got %0d want 512", accepted);
        end
    endtask

    task automatic test_display();
        int p0, q, row, col;
        logic [5:0] e;
        p0 = ((kc / FRAME) + 1) * FRAME;
        for (int i = 0; i < 2 * RP; i++) begin
            goto(p0 + i);
            row = i / RP;
            q   = i % RP;
            col = (q - 1) / 2;
            if (q < 1 || q > 2 * COLS)       e = 6'h00;
            else if (row == 0 && col == 0)   e = 6'h00;
            else                             e = 6'h3F;
            n_cmp++;
            if (rgb() !== e) begin
                n_bad++;
                $display("FAIL display_rgb row=%0d p=%0d got %h want %h", row, q, rgb(), e);
            end
        end
    endtask

    // Pointer at 200, then SOF lands at 0 and the following byte at 1; pointer ends at 20.
    task automatic test_sof_midframe();
        for (int i = 0; i < 200; i++) push(8'h3F);
        push(8'h80);
        push(8'h15);
        for (int i = 0; i < 18; i++) push(8'h3F);
    endtask

    task automatic test_shift_hazard();
        int p0;
        p0 = ((kc / FRAME) + 1) * FRAME;
        goto(p0 + 1);
        n_cmp++;
        if (rgb() !== 6'h00) begin n_bad++; $display("FAIL hazard_col0 got %h want 00", rgb()); end
        goto(p0 + 3);
        n_cmp++;
        if (rgb() !== 6'h15) begin n_bad++; $display("FAIL sof_next_addr1 got %h want 15", rgb()); end
        goto(p0 + 21);
        push(8'h07);
        goto(p0 + 23);
        push(8'h81);
        goto(p0 + 41);
        n_cmp++;
        if (rgb() !== 6'h07) begin n_bad++; $display("FAIL hazard_col20_ph0 got %h want 07", rgb()); end
        goto(p0 + 42);
        n_cmp++;
        if (rgb() !== 6'h07 || led_clk !== 1'b1) begin
            n_bad++; $display("FAIL hazard_col20_ph1 got %h/%b want 07/1", rgb(), led_clk);
        end
        goto(p0 + 43);
        n_cmp++;
        if (rgb() !== 6'h3F) begin n_bad++; $display("FAIL hazard_col21 got %h want 3f", rgb()); end
        goto(p0 + FRAME + 1);
        n_cmp++;
        if (rgb() !== 6'h01) begin n_bad++; $display("FAIL hazard_col0_next got %h want 01", rgb()); end
        goto(p0 + FRAME + 3);
        n_cmp++;
        if (rgb() !== 6'h15) begin n_bad++; $display("FAIL hazard_col1_next got %h want 15", rgb()); end
        goto(p0 + FRAME + 41);
        n_cmp++;
        if (rgb() !== 6'h07) begin n_bad++; $display("FAIL hazard_col20_next got %h want 07", rgb()); end
    endtask

    task automatic test_reset_midshift();
        int pn;
        logic [8:0] e;
        pn = ((kc / RP) + 1) * RP;
        goto(pn + 22);
        n_cmp++;
        if (led_clk !== 1'b1 || rgb() !== 6'h3F) begin
            n_bad++; $display("FAIL midshift_pre got %b/%h want 1/3f", led_clk, rgb());
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({led_clk, oe, lat, wr_ready, frame_done} !== 5'b01000) begin
            n_bad++;
            $display("FAIL midshift_ctrl got %b want 01000", {led_clk, oe, lat, wr_ready, frame_done});
        end
        n_cmp++;
        if (rgb() !== 6'h00) begin n_bad++; $display("FAIL midshift_rgb got %h want 00", rgb()); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int k = 0; k < RP + LP + 5; k++) begin
            goto(k);
            e = exp_ctrl(k);
            n_cmp++;
            if (ctrl() !== e) begin
                n_bad++;
                $display("FAIL restart_ctrl k=%0d got %b want %b", k, ctrl(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_frame_wrap();
        test_fill();
        test_display();
        test_sof_midframe();
        test_shift_hazard();
        test_reset_midshift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
